// File: rtl/float_mul_seq_if.sv
// Operand/result handshake bundle for float_mul_seq.
// master drives operands and takes results; slave is the multiplier.
interface float_mul_seq_if #(
  parameter int NE = 8,
  parameter int NM = 23
);
  localparam int W = 1 + NE + NM;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [2:0]   flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/float_mul_seq.sv
// Sequential radix-2 shift-add floating-point multiplier, one-entry result.
// FLOAT_MUL_RNE_EN selects round-to-nearest-even; default truncates.
module float_mul_seq #(
  parameter int NE = 8,
  parameter int NM = 23
) (
  input  logic           clk,
  input  logic           reset_n,
  float_mul_seq_if.slave bus
);
  localparam int W    = 1 + NE + NM;
  localparam int M    = NM + 1;
  localparam int P    = 2 * M;
  localparam int CW   = $clog2(M + 1);
  localparam int XW   = NE + 2;
  localparam int BIAS = (1 << (NE - 1)) - 1;

  localparam logic signed [XW-1:0] EMAX  = XW'((1 << NE) - 1);
  localparam logic signed [XW-1:0] EONE  = XW'(1);
  localparam logic signed [XW-1:0] EBIAS = XW'(BIAS);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t state, state_nx;

  logic [M-1:0]           mcand;
  logic [M-1:0]           mplier;
  logic [P-1:0]           prod;
  logic [CW-1:0]          cnt;
  logic                   sgn;
  logic signed [XW-1:0]   exp_q;
  logic [W-1:0]           res_q;
  logic [2:0]             flg_q;

  logic          sa, sb;
  logic [NE-1:0] ea, eb;
  logic [NM-1:0] fa, fb;

  assign {sa, ea, fa} = bus.a;
  assign {sb, eb, fb} = bus.b;

  logic a_zero, a_max, a_inf, a_nan;
  logic b_zero, b_max, b_inf, b_nan;
  logic special, sp_nan, sp_inf;

  assign a_zero = (ea == '0);
  assign a_max  = &ea;
  assign a_inf  = a_max && (fa == '0);
  assign a_nan  = a_max && (fa != '0);
  assign b_zero = (eb == '0);
  assign b_max  = &eb;
  assign b_inf  = b_max && (fb == '0);
  assign b_nan  = b_max && (fb != '0);

  assign special = a_zero | a_max | b_zero | b_max;
  assign sp_nan  = a_nan | b_nan
                 | (a_zero & b_inf) | (a_inf & b_zero);
  assign sp_inf  = (a_inf | b_inf) & ~sp_nan;

  logic [W-1:0] spec_res;

  always_comb begin
    spec_res = '0;
    unique case (1'b1)
      sp_nan:  spec_res = {1'b0, {NE{1'b1}}, 1'b1, {(NM-1){1'b0}}};
      sp_inf:  spec_res = {sa ^ sb, {NE{1'b1}}, {NM{1'b0}}};
      default: spec_res = {sa ^ sb, {(W-1){1'b0}}};
    endcase
  end

  logic signed [XW-1:0] exp_sum;

  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - EBIAS;

  logic [M:0] acc_sum;

  assign acc_sum = {1'b0, prod[P-1:M]}
                 + (mplier[0] ? {1'b0, mcand} : '0);

  // Normalise: product of two [1,2) mantissas lies in [1,4)
  logic [M-1:0]         mant;
  logic signed [XW-1:0] exp_n;
  logic                 rnd;

  always_comb begin
    if (prod[P-1]) begin
      mant  = prod[P-1:M];
      exp_n = exp_q + EONE;
    end else begin
      mant  = prod[P-2:M-1];
      exp_n = exp_q;
    end
  end

`ifdef FLOAT_MUL_RNE_EN
  logic guard, sticky;

  always_comb begin
    if (prod[P-1]) begin
      guard  = prod[M-1];
      sticky = |prod[M-2:0];
    end else begin
      guard  = prod[M-2];
      sticky = |prod[M-3:0];
    end
  end

  assign rnd = guard & (sticky | mant[0]);
`else
  assign rnd = 1'b0;
`endif

  logic [M:0]           mant_r;
  logic [NM-1:0]        frac_f;
  logic signed [XW-1:0] exp_f;
  logic [W-1:0]         norm_res;
  logic [2:0]           norm_flg;

  assign mant_r = {1'b0, mant} + (M+1)'(rnd);

  always_comb begin
    if (mant_r[M]) begin
      frac_f = mant_r[NM:1];
      exp_f  = exp_n + EONE;
    end else begin
      frac_f = mant_r[NM-1:0];
      exp_f  = exp_n;
    end
  end

  always_comb begin
    norm_res = {sgn, exp_f[NE-1:0], frac_f};
    norm_flg = 3'b000;
    if (exp_f >= EMAX) begin
      norm_res = {sgn, {NE{1'b1}}, {NM{1'b0}}};
      norm_flg = 3'b010;
    end else if (exp_f < EONE) begin
      norm_res = {sgn, {(W-1){1'b0}}};
      norm_flg = 3'b001;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.in_valid) state_nx = special ? DONE : MUL;
      MUL:  if (cnt == CW'(1)) state_nx = NORM;
      NORM: state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      sgn    <= 1'b0;
      exp_q  <= '0;
      res_q  <= '0;
      flg_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          if (special) begin
            res_q <= spec_res;
            flg_q <= {sp_nan, 2'b00};
          end else begin
            mcand  <= {1'b1, fa};
            mplier <= {1'b1, fb};
            sgn    <= sa ^ sb;
            exp_q  <= exp_sum;
            prod   <= '0;
            cnt    <= CW'(M);
          end
        end
        MUL: begin
          prod   <= {acc_sum, prod[M-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
        end
        NORM: begin
          res_q <= norm_res;
          flg_q <= norm_flg;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;
  assign bus.flags     = flg_q;
endmodule

// File: tb/tb_float_mul_seq.sv
// Directed-vector bench for float_mul_seq at IEEE single defaults.
// Expected values follow FLOAT_MUL_RNE_EN when that macro is defined.
module tb_float_mul_seq;
  localparam int NE = 8;
  localparam int NM = 23;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  float_mul_seq_if #(.NE(NE), .NM(NM)) bus ();

  float_mul_seq #(.NE(NE), .NM(NM)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int passed = 0;

  task automatic issue(input logic [31:0] x, input logic [31:0] y,
                       output bit ok);
    int n = 0;
    ok = 1'b0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) return;
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    ok = 1'b1;
  endtask

  // lat counts edges from accept to the first edge that sees out_valid
  task automatic wait_out(output int lat, output bit ok);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    ok = bus.out_valid;
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic [2:0] f,
                        output int lat, output bit ok);
    bit ok1, ok2;
    issue(x, y, ok1);
    wait_out(lat, ok2);
    r = bus.result;
    f = bus.flags;
    ok = ok1 & ok2;
    if (bus.out_ready && ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      $display("FAIL reset_hs: ready/valid=%b want 10",
               {bus.in_ready, bus.out_valid});
    end else passed++;
    total++;
    if ({bus.flags, bus.result} !== 35'd0) begin
      $display("FAIL reset_data: flags=%b result=%h want 000/0",
               bus.flags, bus.result);
    end else passed++;
  endtask

  task automatic test_basic;
    logic [31:0] r;
    logic [2:0] f;
    int lat;
    bit ok;
    run_op(32'h3FC00000, 32'h40000000, r, f, lat, ok);
    total++;
    if (!ok) $display("FAIL basic_timeout: ok=%0b want 1", ok);
    else passed++;
    total++;
    if (r !== 32'h40400000) $display("FAIL basic_res: %h want 40400000", r);
    else passed++;
    total++;
    if (f !== 3'b000) $display("FAIL basic_flags: %b want 000", f);
    else passed++;
    total++;
    if (lat !== 26) $display("FAIL basic_lat: %0d want 26", lat);
    else passed++;
  endtask

  task automatic test_rounding;
    logic [31:0] r, want;
    logic [2:0] f;
    int lat;
    bit ok;
`ifdef FLOAT_MUL_RNE_EN
    want = 32'h3FC00002;
`else
    want = 32'h3FC00001;
`endif
    run_op(32'h3F800001, 32'h3FC00000, r, f, lat, ok);
    total++;
    if (r !== want || f !== 3'b000 || !ok) begin
      $display("FAIL round_tie: %h/%b want %h/000", r, f, want);
    end else passed++;
  endtask

  task automatic test_normals;
    logic [31:0] r;
    logic [2:0] f;
    int lat;
    bit ok;
    run_op(32'hC0400000, 32'h40400000, r, f, lat, ok);
    total++;
    if (r !== 32'hC1100000 || f !== 3'b000 || !ok) begin
      $display("FAIL neg_mul: %h/%b want c1100000/000", r, f);
    end else passed++;
    run_op(32'h7F000000, 32'h7F000000, r, f, lat, ok);
    total++;
    if (r !== 32'h7F800000 || f !== 3'b010 || !ok) begin
      $display("FAIL overflow: %h/%b want 7f800000/010", r, f);
    end else passed++;
    run_op(32'h00800000, 32'h80800000, r, f, lat, ok);
    total++;
    if (r !== 32'h80000000 || f !== 3'b001 || !ok) begin
      $display("FAIL underflow: %h/%b want 80000000/001", r, f);
    end else passed++;
  endtask

  task automatic test_specials;
    logic [31:0] r;
    logic [2:0] f;
    int lat;
    bit ok;
    run_op(32'h00000000, 32'h7F800000, r, f, lat, ok);
    total++;
    if (r !== 32'h7FC00000 || f !== 3'b100 || !ok) begin
      $display("FAIL zero_inf: %h/%b want 7fc00000/100", r, f);
    end else passed++;
    total++;
    if (lat !== 1) $display("FAIL special_lat: %0d want 1", lat);
    else passed++;
    run_op(32'h80000000, 32'h3F800000, r, f, lat, ok);
    total++;
    if (r !== 32'h80000000 || f !== 3'b000 || !ok) begin
      $display("FAIL neg_zero: %h/%b want 80000000/000", r, f);
    end else passed++;
    run_op(32'hFFC00001, 32'h3F800000, r, f, lat, ok);
    total++;
    if (r !== 32'h7FC00000 || f !== 3'b100 || !ok) begin
      $display("FAIL nan_in: %h/%b want 7fc00000/100", r, f);
    end else passed++;
    run_op(32'h7F800000, 32'hC0000000, r, f, lat, ok);
    total++;
    if (r !== 32'hFF800000 || f !== 3'b000 || !ok) begin
      $display("FAIL inf_norm: %h/%b want ff800000/000", r, f);
    end else passed++;
    run_op(32'h00000001, 32'h3F800000, r, f, lat, ok);
    total++;
    if (r !== 32'h00000000 || f !== 3'b000 || !ok) begin
      $display("FAIL denorm_flush: %h/%b want 00000000/000", r, f);
    end else passed++;
  endtask

  task automatic test_backpressure;
    int lat;
    bit ok1, ok2;
    bus.out_ready = 1'b0;
    issue(32'h40400000, 32'h40400000, ok1);
    wait_out(lat, ok2);
    total++;
    if (!(ok1 && ok2)) $display("FAIL bp_timeout: ok=%0b want 1", ok1 & ok2);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.a = 32'h3F800000;
      bus.b = 32'h40000000;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      total++;
      if ({bus.out_valid, bus.in_ready, bus.flags, bus.result}
          !== {1'b1, 1'b0, 3'b000, 32'h41100000}) begin
        $display("FAIL bp_hold%0d: v=%b r=%b f=%b res=%h want 1/0/000/41100000",
                 i, bus.out_valid, bus.in_ready, bus.flags, bus.result);
      end else passed++;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      $display("FAIL bp_release: valid/ready=%b want 01",
               {bus.out_valid, bus.in_ready});
    end else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      $display("FAIL bp_once: valid/ready=%b want 01",
               {bus.out_valid, bus.in_ready});
    end else passed++;
  endtask

  task automatic test_back_to_back;
    int gap, lat;
    bit ok;
    @(negedge clk);
    bus.a = 32'h3FC00000;
    bus.b = 32'h3FC00000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    gap = 1;
    @(negedge clk);
    while (!bus.in_ready && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    total++;
    if (gap !== 27) $display("FAIL b2b_gap: %0d want 27", gap);
    else passed++;
    wait_out(lat, ok);
    total++;
    if (bus.result !== 32'h40100000 || !ok) begin
      $display("FAIL b2b_res: %h want 40100000", bus.result);
    end else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    logic [2:0] f;
    int lat;
    bit ok;
    issue(32'h40400000, 32'h40000000, ok);
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      $display("FAIL rst_mid: valid/ready=%b want 01",
               {bus.out_valid, bus.in_ready});
    end else passed++;
    total++;
    if (bus.result !== 32'h0) $display("FAIL rst_res: %h want 0", bus.result);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    run_op(32'h40000000, 32'h40000000, r, f, lat, ok);
    total++;
    if (r !== 32'h40800000 || f !== 3'b000 || !ok) begin
      $display("FAIL rst_after: %h/%b want 40800000/000", r, f);
    end else passed++;
    total++;
    if (lat !== 26) $display("FAIL rst_after_lat: %0d want 26", lat);
    else passed++;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset;
    test_basic;
    test_rounding;
    test_normals;
    test_specials;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
